// File: rtl/speed_calc_scheduler.sv
`default_nettype none
// speed_calc_scheduler: once-per-second avs/spd computation through one shared restoring divider.
// Rev 1.0 - initial release.
module speed_calc_scheduler #(
  parameter int CIRC_MM = 2100,
  parameter int DIV_CYC = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1s,
  input  logic [13:0] day,
  input  logic [19:0] tim,
  input  logic [15:0] wheel_period,
  output logic [9:0]  avs,
  output logic [9:0]  spd,
  output logic        busy,
  output logic        done
);

  localparam int                CNT_W        = $clog2(DIV_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DIV_CYC - 1);
  localparam logic [25:0]       SPD_DIVIDEND = 26'(CIRC_MM * 36);
  localparam logic [25:0]       HOUR_S       = 26'd3600;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AVS_DIV = 3'd1,
    AVS_WB  = 3'd2,
    SPD_DIV = 3'd3,
    SPD_WB  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              start;
  logic              pending;
  logic [15:0]       wp_r;
  logic [19:0]       div_r;
  logic [20:0]       rem_r;
  logic [25:0]       quo_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [20:0]       trial;
  logic              fits;
  logic [9:0]        result;

  // The quotient register doubles as the dividend shifter: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign trial  = {rem_r[19:0], quo_r[25]};
  assign fits   = (trial >= {1'b0, div_r});
  assign result = (div_r == '0)      ? 10'd0   :
                  (quo_r > 26'd999)  ? 10'd999 : quo_r[9:0];
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_1s) begin
          start    = 1'b1;
          state_nx = (tim == '0) ? AVS_WB : AVS_DIV;
        end
      end
      AVS_DIV: begin
        if (cnt_r == CNT_LAST) state_nx = AVS_WB;
      end
      AVS_WB: begin
        state_nx = (wp_r == '0) ? SPD_WB : SPD_DIV;
      end
      SPD_DIV: begin
        if (cnt_r == CNT_LAST) state_nx = SPD_WB;
      end
      SPD_WB: begin
        // A tick arriving on this very edge is treated like an already pending one.
        if (pending || tick_1s) begin
          start    = 1'b1;
          state_nx = (tim == '0) ? AVS_WB : AVS_DIV;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avs     <= '0;
      spd     <= '0;
      done    <= 1'b0;
      pending <= 1'b0;
      wp_r    <= '0;
      div_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      cnt_r   <= '0;
    end else begin
      done <= (state == SPD_WB);
      if (state == AVS_WB) avs <= result;
      if (state == SPD_WB) spd <= result;

      if (start) begin
        pending <= 1'b0;
      end else if (busy && tick_1s) begin
        pending <= 1'b1;
      end

      if (start) begin
        wp_r  <= wheel_period;
        div_r <= tim;
        quo_r <= {12'd0, day} * HOUR_S;
        rem_r <= '0;
        cnt_r <= '0;
      end else if (state == AVS_WB) begin
        div_r <= {4'd0, wp_r};
        quo_r <= SPD_DIVIDEND;
        rem_r <= '0;
        cnt_r <= '0;
      end else if (state == AVS_DIV || state == SPD_DIV) begin
        rem_r <= fits ? (trial - {1'b0, div_r}) : trial;
        quo_r <= {quo_r[24:0], fits};
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_speed_calc_scheduler.sv
`default_nettype none
// tb_speed_calc_scheduler: job-level reference model feeding a scoreboard, checked every cycle.
// Rev 1.0 - initial release.
module tb_speed_calc_scheduler;

  localparam int CIRC_MM = 2100;
  localparam int DIV_CYC = 26;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1s = 1'b0;
  logic [13:0] day = '0;
  logic [19:0] tim = '0;
  logic [15:0] wheel_period = '0;
  logic [9:0]  avs, spd;
  logic        busy, done;

  speed_calc_scheduler #(.CIRC_MM(CIRC_MM), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .day(day), .tim(tim),
    .wheel_period(wheel_period), .avs(avs), .spd(spd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     avs;
    int     spd;
    longint t_avs;
    longint t_done;
  } job_t;

  job_t   q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     m_busy = 1'b0;
  bit     m_pending = 1'b0;
  longint m_end = 0;
  int     exp_avs = 0;
  int     exp_spd = 0;

  function automatic int clamp_div(longint num, longint den);
    if (den == 0) return 0;
    if (num / den > 999) return 999;
    return int'(num / den);
  endfunction

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Expected results and the cycles at which they must appear, from plain arithmetic.
  task automatic start_job();
    job_t j;
    j.avs    = clamp_div(longint'(day) * 3600, longint'(tim));
    j.spd    = clamp_div(longint'(CIRC_MM) * 36, longint'(wheel_period));
    j.t_avs  = cyc + ((tim == 0) ? 1 : DIV_CYC + 1);
    j.t_done = j.t_avs + ((wheel_period == 0) ? 1 : DIV_CYC + 1);
    m_end    = j.t_done;
    m_busy   = 1'b1;
    q.push_back(j);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_busy    = 1'b0;
      m_pending = 1'b0;
    end else if (m_busy && cyc == m_end) begin
      if (m_pending || tick_1s) start_job();
      else m_busy = 1'b0;
      m_pending = 1'b0;
    end else if (m_busy) begin
      if (tick_1s) m_pending = 1'b1;
    end else if (tick_1s) begin
      start_job();
    end
  end

  always @(negedge clk) begin
    bit exp_done;
    exp_done = 1'b0;
    if (!reset) begin
      q.delete();
      exp_avs = 0;
      exp_spd = 0;
    end else if (q.size() > 0) begin
      if (cyc == q[0].t_avs) exp_avs = q[0].avs;
      if (cyc == q[0].t_done) begin
        exp_spd  = q[0].spd;
        exp_done = 1'b1;
        void'(q.pop_front());
      end
    end
    check("avs", int'(avs), exp_avs);
    check("spd", int'(spd), exp_spd);
    check("done", int'(done), int'(exp_done));
    check("busy", int'(busy), int'(m_busy));
  end

  task automatic set_ops(int d, int t, int w);
    day          = 14'(d);
    tim          = 20'(t);
    wheel_period = 16'(w);
  endtask

  // Called just after a falling edge; the tick is sampled at the next rising edge and
  // the task returns just before the rising edge 'gap' cycles later.
  task automatic tick_then(int gap);
    tick_1s = 1'b1;
    @(negedge clk);
    tick_1s = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic reset_pulse(int len);
    #1 reset = 1'b0;
    repeat (len) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    set_ops(100, 1800, 378);   tick_then(70);   // nominal 200 / 200
    set_ops(50, 0, 0);         tick_then(10);   // both divisors zero
    set_ops(16383, 1, 10);     tick_then(60);   // clamp both
    set_ops(1, 7, 1000);       tick_then(60);   // truncation 514 / 75
    set_ops(500, 0, 378);      tick_then(40);   // tim zero only
    set_ops(100, 1800, 0);     tick_then(40);   // wheel stopped only

    // Overlap: input change mid-job, two ticks while busy, single rerun.
    set_ops(100, 1800, 378);
    tick_then(5);
    day = 14'd200;
    repeat (5) @(negedge clk);
    tick_then(10);
    tick_then(100);

    // Tick landing on the final writeback edge.
    set_ops(300, 3600, 500);   tick_then(54);
    set_ops(10, 60, 2000);     tick_then(120);

    // Pending set, then a further tick on the writeback edge is dropped.
    set_ops(7, 9, 123);        tick_then(30);
    tick_then(24);
    tick_then(120);

    // Reset mid-job.
    set_ops(100, 1800, 378);   tick_then(15);
    reset_pulse(5);
    repeat (60) @(negedge clk);

    for (int i = 0; i < 70; i++) begin
      int d, t, w, sel;
      d   = $urandom_range(0, 16383);
      sel = $urandom_range(0, 7);
      t   = (sel == 0) ? 0 : (sel < 3) ? $urandom_range(1, 20) : $urandom_range(1, 200000);
      sel = $urandom_range(0, 7);
      w   = (sel == 0) ? 0 : (sel < 3) ? $urandom_range(1, 60) : $urandom_range(60, 5000);
      set_ops(d, t, w);
      if ($urandom_range(0, 29) == 0) reset_pulse($urandom_range(1, 4));
      tick_then($urandom_range(2, 80));
    end

    set_ops(0, 0, 0);
    repeat (150) @(negedge clk);
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
